// File: rtl/itcm_boot_loader_if.sv
// Byte-stream and ITCM SRAM buses of the boot loader: the image stream in,
// the core-side SRAM port in, and the ITCM macro port out.
interface itcm_boot_loader_if #(
  parameter int AW = 14
) ();
  logic          byte_vld;
  logic          byte_rdy;
  logic [7:0]    byte_dat;

  logic          cpu_ram_cs;
  logic          cpu_ram_we;
  logic [AW-1:0] cpu_ram_addr;
  logic [7:0]    cpu_ram_wem;
  logic [63:0]   cpu_ram_din;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wem;
  logic [63:0]   ram_din;

  // The loader is the slave of the stream and core port, master of the macro
  modport slave (
    input  byte_vld, byte_dat,
    output byte_rdy,
    input  cpu_ram_cs, cpu_ram_we, cpu_ram_addr, cpu_ram_wem, cpu_ram_din,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din
  );

  modport master (
    output byte_vld, byte_dat,
    input  byte_rdy,
    output cpu_ram_cs, cpu_ram_we, cpu_ram_addr, cpu_ram_wem, cpu_ram_din,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din
  );
endinterface

// File: rtl/itcm_boot_loader.sv
// Boot loader owning the ITCM SRAM port: packs a byte stream into 64-bit words,
// writes them to ITCM, then releases core reset. `ITCM_LOADER_CKSUM_EN adds a byte-sum trailer check.
module itcm_boot_loader #(
  parameter int ITCM_DP = 16384,
  parameter int AW      = 14,
  parameter int LW      = 15
) (
  input  logic              hfclk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic [LW-1:0]     load_len_i,
  itcm_boot_loader_if.slave bus,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RUN,
    S_ERR
`ifdef ITCM_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] word_cnt_q, word_cnt_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [63:0]   word_buf_q, word_buf_d;
`ifdef ITCM_LOADER_CKSUM_EN
  logic [31:0]   sum_q, sum_d;
  logic [23:0]   exp_q, exp_d;
`endif

  logic          byte_rdy;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wem;
  logic [63:0]   ram_din;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Datapath registers are always written through the FSM before being used
  always_ff @(posedge hfclk) begin
    word_buf_q <= word_buf_d;
`ifdef ITCM_LOADER_CKSUM_EN
    sum_q      <= sum_d;
    exp_q      <= exp_d;
`endif
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
`ifdef ITCM_LOADER_CKSUM_EN
    sum_d      = sum_q;
    exp_d      = exp_q;
`endif
    byte_rdy   = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wem    = '0;
    ram_din    = '0;

    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          if (load_len_i == '0) begin
            state_d = S_RUN;
          end else if (load_len_i > LW'(ITCM_DP)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_COLLECT;
            len_d      = load_len_i;
            word_cnt_d = '0;
            byte_idx_d = '0;
`ifdef ITCM_LOADER_CKSUM_EN
            sum_d      = '0;
`endif
          end
        end
      end

      S_COLLECT: begin
        byte_rdy = 1'b1;
        if (bus.byte_vld) begin
          word_buf_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_dat;
          byte_idx_d = byte_idx_q + 3'd1;
`ifdef ITCM_LOADER_CKSUM_EN
          sum_d      = sum_q + 32'(bus.byte_dat);
`endif
          if (byte_idx_q == 3'd7) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        ram_cs     = 1'b1;
        ram_we     = 1'b1;
        ram_wem    = 8'hFF;
        ram_addr   = word_cnt_q[AW-1:0];
        ram_din    = word_buf_q;
        word_cnt_d = word_cnt_q + LW'(1);
        if (word_cnt_d == len_q) begin
`ifdef ITCM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end

`ifdef ITCM_LOADER_CKSUM_EN
      // byte_idx wrapped to 0 after the last image byte; trailer is little-endian
      S_CKSUM: begin
        byte_rdy = 1'b1;
        if (bus.byte_vld) begin
          exp_d      = {bus.byte_dat, exp_q[23:8]};
          byte_idx_d = byte_idx_q + 3'd1;
          if (byte_idx_q == 3'd3) begin
            state_d = ({bus.byte_dat, exp_q} == sum_q) ? S_RUN : S_ERR;
          end
        end
      end
`endif

      S_RUN: begin
        ram_cs   = bus.cpu_ram_cs;
        ram_we   = bus.cpu_ram_we;
        ram_addr = bus.cpu_ram_addr;
        ram_wem  = bus.cpu_ram_wem;
        ram_din  = bus.cpu_ram_din;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are sticky and rise together with the state they report
    cpu_rst_n_d = cpu_rst_n_q | (state_d == S_RUN);
    done_d      = done_q | (state_d == S_RUN);
    err_d       = err_q | (state_d == S_ERR);
  end

  assign bus.byte_rdy = byte_rdy;
  assign bus.ram_cs   = ram_cs;
  assign bus.ram_we   = ram_we;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_wem  = ram_wem;
  assign bus.ram_din  = ram_din;

  assign cpu_rst_n_o = cpu_rst_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef ITCM_LOADER_CKSUM_EN
  assign busy_o      = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CKSUM);
`else
  assign busy_o      = (state_q == S_COLLECT) || (state_q == S_WRITE);
`endif

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Self-checking bench for itcm_boot_loader: random images checked against a
// word-packing model of ITCM contents, plus reset, error, pass-through and boundary scenarios.
module tb_itcm_boot_loader;
  localparam int DP = 1024;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          hfclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [LW-1:0] load_len = '0;
  logic          cpu_rst_n, busy, done, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  itcm_boot_loader_if #(.AW(AW)) bus ();

  itcm_boot_loader #(.ITCM_DP(DP), .AW(AW), .LW(LW)) dut (
    .hfclk        (hfclk),
    .rst_n        (rst_n),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .bus          (bus),
    .cpu_rst_n_o  (cpu_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 hfclk = ~hfclk;
  always @(posedge hfclk) cyc++;

  // Write monitor, sampled mid-cycle
  logic [AW-1:0] wr_addr[$];
  logic [63:0]   wr_din[$];
  logic [7:0]    wr_wem[$];
  int            wr_cyc[$];
  int            cs_cnt = 0;
  int            rise_cyc = -1;
  logic          prev_rst = 1'b0;

  always @(negedge hfclk) begin
    if (bus.ram_cs === 1'b1) begin
      cs_cnt++;
      if (bus.ram_we === 1'b1) begin
        wr_addr.push_back(bus.ram_addr);
        wr_din.push_back(bus.ram_din);
        wr_wem.push_back(bus.ram_wem);
        wr_cyc.push_back(cyc);
      end
    end
    if (cpu_rst_n === 1'b1 && prev_rst !== 1'b1) rise_cyc = cyc;
    prev_rst = cpu_rst_n;
  end

  // Reference model: word w of the image is bytes 8w..8w+7, byte 0 least significant
  function automatic logic [63:0] model_word(input logic [7:0] img[$], input int w);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = v + (64'(img[8*w+k]) << (8*k));
    return v;
  endfunction

  function automatic logic [31:0] model_sum(input logic [7:0] img[$]);
    logic [31:0] s = '0;
    foreach (img[i]) s = s + 32'(img[i]);
    return s;
  endfunction

  task automatic clear_mon();
    wr_addr.delete(); wr_din.delete(); wr_wem.delete(); wr_cyc.delete();
    cs_cnt = 0;
    rise_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge hfclk); #1;
    rst_n = 1'b0;
    load_start = 1'b0;
    bus.byte_vld = 1'b0;
    repeat (2) @(posedge hfclk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic pulse_start(input int len);
    load_start = 1'b1;
    load_len = LW'(len);
    @(posedge hfclk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge hfclk); #1; end
    bus.byte_vld = 1'b1;
    bus.byte_dat = b;
    forever begin
      @(negedge hfclk);
      if (bus.byte_rdy === 1'b1) break;
      n++;
      if (n > 50) begin
        tests++; fails++;
        $display("FAIL byte_accept_timeout: byte_rdy=%b required 1", bus.byte_rdy);
        break;
      end
    end
    @(posedge hfclk); #1;
    bus.byte_vld = 1'b0;
  endtask

  // Image bytes, then (with the checksum feature) the 4-byte trailer
  task automatic run_load(input int len, input logic [7:0] img[$], input int gapmax, input bit good_ck);
    logic [31:0] ck;
    pulse_start(len);
    foreach (img[i]) send_byte(img[i], (gapmax < 0) ? 1 : $urandom_range(0, gapmax));
`ifdef ITCM_LOADER_CKSUM_EN
    ck = model_sum(img) + (good_ck ? 32'd0 : 32'd1);
    for (int k = 0; k < 4; k++) send_byte(ck[8*k +: 8], 0);
`else
    ck = good_ck ? 32'd0 : 32'd1;
`endif
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < budget) begin
      @(negedge hfclk);
      n++;
    end
    if (!(done === 1'b1 || err === 1'b1)) begin
      tests++; fails++;
      $display("FAIL done_timeout: done=%b err=%b required one of them 1", done, err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge hfclk);
    tests++; if (cpu_rst_n !== 1'b0) begin fails++; $display("FAIL reset_cpu_rst_n: got %b required 0", cpu_rst_n); end
    tests++; if (bus.byte_rdy !== 1'b0) begin fails++; $display("FAIL reset_byte_rdy: got %b required 0", bus.byte_rdy); end
    tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: busy/done/err got %b required 000", {busy, done, err}); end
    tests++; if (bus.ram_cs !== 1'b0) begin fails++; $display("FAIL reset_ram_cs: got %b required 0", bus.ram_cs); end
  endtask

  task automatic test_two_words();
    logic [7:0] img[$];
    do_reset();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    run_load(2, img, 0, 1'b1);
    wait_done(100);
    @(negedge hfclk);
    tests++; if (wr_addr.size() != 2) begin fails++; $display("FAIL two_words_count: got %0d required 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      tests++; if (wr_addr[0] !== 10'd0 || wr_din[0] !== 64'h0706050403020100) begin fails++; $display("FAIL two_words_w0: addr %0h din %h required 0 / 0706050403020100", wr_addr[0], wr_din[0]); end
      tests++; if (wr_addr[1] !== 10'd1 || wr_din[1] !== 64'h0F0E0D0C0B0A0908) begin fails++; $display("FAIL two_words_w1: addr %0h din %h required 1 / 0F0E0D0C0B0A0908", wr_addr[1], wr_din[1]); end
      tests++; if (wr_wem[0] !== 8'hFF || wr_wem[1] !== 8'hFF) begin fails++; $display("FAIL two_words_wem: got %h %h required FF FF", wr_wem[0], wr_wem[1]); end
      tests++; if (wr_cyc[1] - wr_cyc[0] != 9) begin fails++; $display("FAIL two_words_spacing: got %0d cycles required 9", wr_cyc[1] - wr_cyc[0]); end
`ifndef ITCM_LOADER_CKSUM_EN
      tests++; if (rise_cyc != wr_cyc[1] + 1) begin fails++; $display("FAIL two_words_release: cpu_rst_n rose at cycle %0d required %0d", rise_cyc, wr_cyc[1] + 1); end
`else
      tests++; if (rise_cyc <= wr_cyc[1]) begin fails++; $display("FAIL two_words_release: cpu_rst_n rose at cycle %0d required after %0d", rise_cyc, wr_cyc[1]); end
`endif
    end
    tests++; if ({cpu_rst_n, done, err, busy} !== 4'b1100) begin fails++; $display("FAIL two_words_status: rst_n/done/err/busy got %b required 1100", {cpu_rst_n, done, err, busy}); end
  endtask

  task automatic test_passthrough();
    logic [63:0] d;
    int cs_before;
    d = {$urandom, $urandom};
    @(posedge hfclk); #1;
    bus.cpu_ram_cs = 1'b1; bus.cpu_ram_we = 1'b0; bus.cpu_ram_addr = 10'h123;
    bus.cpu_ram_wem = 8'h0F; bus.cpu_ram_din = d;
    #1;
    tests++; if (bus.ram_cs !== 1'b1 || bus.ram_addr !== 10'h123) begin fails++; $display("FAIL pass_cs_addr: cs %b addr %0h required 1 / 123", bus.ram_cs, bus.ram_addr); end
    tests++; if (bus.ram_we !== 1'b0 || bus.ram_wem !== 8'h0F || bus.ram_din !== d) begin fails++; $display("FAIL pass_data: we %b wem %h din %h required 0 / 0F / %h", bus.ram_we, bus.ram_wem, bus.ram_din, d); end
    @(posedge hfclk); #1;
    bus.cpu_ram_cs = 1'b0;
    cs_before = cs_cnt;
    pulse_start(1);
    bus.byte_vld = 1'b1; bus.byte_dat = 8'hAA;
    repeat (3) @(negedge hfclk);
    tests++; if (bus.byte_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || cpu_rst_n !== 1'b1) begin fails++; $display("FAIL restart_ignored: rdy/busy/done/rst_n got %b required 0011", {bus.byte_rdy, busy, done, cpu_rst_n}); end
    tests++; if (cs_cnt != cs_before) begin fails++; $display("FAIL restart_no_access: got %0d ram_cs cycles required 0", cs_cnt - cs_before); end
    @(posedge hfclk); #1;
    bus.byte_vld = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] img[$];
    logic [63:0] exp_w;
    do_reset();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    exp_w = model_word(img, 0);
    run_load(1, img, -1, 1'b1);
    wait_done(100);
    tests++; if (wr_din.size() != 1 || wr_din[0] !== exp_w || wr_addr[0] !== 10'd0) begin fails++; $display("FAIL stall_word: %0d writes, din %h required 1 write of %h", wr_din.size(), (wr_din.size() > 0) ? wr_din[0] : 64'h0, exp_w); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done: got %b required 1", done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] img[$];
      int len, bad;
      do_reset();
      len = $urandom_range(1, 6);
      for (int i = 0; i < 8 * len; i++) img.push_back(8'($urandom));
      run_load(len, img, 2, 1'b1);
      wait_done(400);
      @(negedge hfclk);
      bad = 0;
      for (int w = 0; w < len && w < wr_din.size(); w++)
        if (wr_addr[w] !== AW'(w) || wr_din[w] !== model_word(img, w) || wr_wem[w] !== 8'hFF) bad++;
      tests++; if (wr_din.size() != len || bad != 0) begin fails++; $display("FAIL random_image: len %0d got %0d writes, %0d wrong, required %0d writes, 0 wrong", len, wr_din.size(), bad, len); end
      tests++; if ({cpu_rst_n, done, err} !== 3'b110) begin fails++; $display("FAIL random_status: rst_n/done/err got %b required 110", {cpu_rst_n, done, err}); end
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    pulse_start(0);
    @(negedge hfclk);
    tests++; if ({cpu_rst_n, done, err} !== 3'b110) begin fails++; $display("FAIL len_zero: rst_n/done/err got %b required 110", {cpu_rst_n, done, err}); end
    tests++; if (cs_cnt != 0) begin fails++; $display("FAIL len_zero_writes: got %0d ram_cs cycles required 0", cs_cnt); end
  endtask

  task automatic test_err();
    do_reset();
    pulse_start(DP + 1);
    @(negedge hfclk);
    tests++; if ({err, cpu_rst_n, bus.byte_rdy, busy, done} !== 5'b10000) begin fails++; $display("FAIL err_entry: err/rst_n/rdy/busy/done got %b required 10000", {err, cpu_rst_n, bus.byte_rdy, busy, done}); end
    @(posedge hfclk); #1;
    pulse_start(1);
    bus.byte_vld = 1'b1; bus.byte_dat = 8'h55;
    repeat (12) @(negedge hfclk);
    bus.byte_vld = 1'b0;
    tests++; if (err !== 1'b1 || bus.byte_rdy !== 1'b0 || cs_cnt != 0) begin fails++; $display("FAIL err_sticky: err %b rdy %b ram_cs cycles %0d required 1 / 0 / 0", err, bus.byte_rdy, cs_cnt); end
  endtask

  task automatic test_midload_reset();
    logic [7:0] img[$];
    do_reset();
    pulse_start(1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    tests++; if (busy !== 1'b1 || bus.byte_rdy !== 1'b1) begin fails++; $display("FAIL midload_busy: busy %b rdy %b required 1 1", busy, bus.byte_rdy); end
    rst_n = 1'b0;
    #1;
    tests++; if ({cpu_rst_n, bus.byte_rdy, busy, done, err, bus.ram_cs} !== 6'b000000) begin fails++; $display("FAIL midload_reset_values: got %b required 000000", {cpu_rst_n, bus.byte_rdy, busy, done, err, bus.ram_cs}); end
    @(posedge hfclk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge hfclk);
    tests++; if (cs_cnt != 0 || busy !== 1'b0) begin fails++; $display("FAIL midload_no_write: ram_cs cycles %0d busy %b required 0 0", cs_cnt, busy); end
    @(posedge hfclk); #1;
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    run_load(1, img, 1, 1'b1);
    wait_done(200);
    tests++; if (wr_din.size() != 1 || wr_din[0] !== model_word(img, 0) || done !== 1'b1) begin fails++; $display("FAIL midload_fresh: %0d writes done %b required 1 write of %h and done", wr_din.size(), done, model_word(img, 0)); end
  endtask

  task automatic test_boundary();
    logic [7:0] img[$];
    int bad;
    do_reset();
    for (int i = 0; i < 8 * DP; i++) img.push_back(8'($urandom));
    run_load(DP, img, 0, 1'b1);
    wait_done(200);
    @(negedge hfclk);
    bad = 0;
    for (int w = 0; w < DP && w < wr_din.size(); w++)
      if (wr_addr[w] !== AW'(w) || wr_din[w] !== model_word(img, w)) bad++;
    tests++; if (wr_din.size() != DP || bad != 0) begin fails++; $display("FAIL boundary_image: %0d writes %0d wrong required %0d writes 0 wrong", wr_din.size(), bad, DP); end
    tests++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== AW'(DP - 1)) begin fails++; $display("FAIL boundary_last_addr: got %0h required %0h", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : '0, DP - 1); end
    tests++; if ({done, err} !== 2'b10) begin fails++; $display("FAIL boundary_status: done/err got %b required 10", {done, err}); end
  endtask

`ifdef ITCM_LOADER_CKSUM_EN
  task automatic test_cksum();
    logic [7:0] img[$];
    for (int i = 0; i < 8; i++) img.push_back(8'h01);
    do_reset();
    run_load(1, img, 0, 1'b1);
    wait_done(100);
    tests++; if ({cpu_rst_n, done, err} !== 3'b110) begin fails++; $display("FAIL cksum_good: rst_n/done/err got %b required 110", {cpu_rst_n, done, err}); end
    do_reset();
    run_load(1, img, 0, 1'b0);
    wait_done(100);
    @(negedge hfclk);
    tests++; if ({cpu_rst_n, done, err} !== 3'b001) begin fails++; $display("FAIL cksum_bad: rst_n/done/err got %b required 001", {cpu_rst_n, done, err}); end
    tests++; if (wr_din.size() != 1 || wr_din[0] !== 64'h0101010101010101) begin fails++; $display("FAIL cksum_bad_write: %0d writes required 1 of 0101010101010101", wr_din.size()); end
  endtask
`endif

  initial begin
    bus.byte_vld = 1'b0;
    bus.byte_dat = 8'h00;
    bus.cpu_ram_cs = 1'b0;
    bus.cpu_ram_we = 1'b0;
    bus.cpu_ram_addr = '0;
    bus.cpu_ram_wem = 8'h00;
    bus.cpu_ram_din = 64'h0;
    test_reset();
    test_two_words();
    test_passthrough();
    test_stall();
    test_random();
    test_len_zero();
    test_err();
    test_midload_reset();
    test_boundary();
`ifdef ITCM_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
